// File: rtl/tile_read_arbiter.sv
// Round-robin arbiter sharing the vector-buffer tile read port among NUM_REQ burst requesters.
// Optional feature: define TILE_ARB_WATCHDOG_EN to abort bursts whose returns stall for 16 DRAIN cycles.
module tile_read_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int TILE_ELEMS   = 32,
  parameter int NUM_REQ      = 2,
  parameter int CNT_W        = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_REQ-1:0]                         req_valid,
  input  logic [NUM_REQ-1:0][4:0]                    req_buffer_id,
  input  logic [NUM_REQ-1:0][CNT_W-1:0]              req_num_tiles,
  output logic [NUM_REQ-1:0]                         req_ready,
  output logic [NUM_REQ-1:0]                         rsp_valid,
  output logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0] rsp_tile,
  output logic                                       rsp_last,
  output logic                                       rd_enable,
  output logic [4:0]                                 rd_buffer_id,
  input  logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0] rd_tile,
  input  logic                                       rd_valid,
  output logic                                       busy,
  output logic                                       err
);

  localparam int PTR_W   = (NUM_REQ > 2) ? 2 : 1;
  localparam int FLUSH_W = $clog2(READ_LATENCY + 2);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t               state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     owner;
  logic [CNT_W-1:0]     num_tiles;
  logic [CNT_W-1:0]     issue_cnt;
  logic [CNT_W-1:0]     rcv_cnt;
  logic [FLUSH_W-1:0]   flush_cnt;
`ifdef TILE_ARB_WATCHDOG_EN
  logic [4:0]           wd_cnt;
`endif

  logic                 grant_found;
  logic [PTR_W-1:0]     grant_idx;
  logic                 beat_ok;
  logic                 stray;
  logic                 burst_done;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // First asserting requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[wrap_inc(rr_ptr, i)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_inc(rr_ptr, i);
      end
    end
  end

  // Beats still in flight from a burst aborted by reset are swallowed during flush_cnt.
  assign beat_ok    = rd_valid && !rst && (flush_cnt == '0) && (state != IDLE) && (rcv_cnt != num_tiles);
  assign stray      = rd_valid && (flush_cnt == '0) && !beat_ok;
  assign rsp_last   = beat_ok && (rcv_cnt == num_tiles - ONE);
  assign burst_done = (rcv_cnt == num_tiles) || rsp_last;
  assign rsp_tile   = rd_tile;
  assign busy       = (state != IDLE);

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == IDLE && grant_found && !rst) req_ready[grant_idx] = 1'b1;
    if (beat_ok) rsp_valid[owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      num_tiles    <= '0;
      issue_cnt    <= '0;
      rcv_cnt      <= '0;
      rd_enable    <= 1'b0;
      rd_buffer_id <= '0;
      err          <= 1'b0;
      flush_cnt    <= FLUSH_W'(READ_LATENCY);
`ifdef TILE_ARB_WATCHDOG_EN
      wd_cnt       <= '0;
`endif
    end else begin
      // NOTE: later non-blocking assignments in this block override the defaults just below.
      if (flush_cnt != '0) flush_cnt <= flush_cnt - FLUSH_W'(1);
      if (stray)           err       <= 1'b1;
      if (beat_ok)         rcv_cnt   <= rcv_cnt + ONE;

      case (state)
        IDLE: begin
          if (grant_found) begin
            owner     <= grant_idx;
            num_tiles <= req_num_tiles[grant_idx];
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            if (req_num_tiles[grant_idx] == '0) begin
              rr_ptr <= wrap_inc(grant_idx, 1);
            end else begin
              state        <= ISSUE;
              rd_enable    <= 1'b1;
              rd_buffer_id <= req_buffer_id[grant_idx];
            end
          end
        end
        ISSUE: begin
          if (issue_cnt == num_tiles - ONE) begin
            rd_enable <= 1'b0;
            state     <= DRAIN;
`ifdef TILE_ARB_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
          end else begin
            issue_cnt <= issue_cnt + ONE;
          end
        end
        DRAIN: begin
          if (burst_done) begin
            state  <= IDLE;
            rr_ptr <= wrap_inc(owner, 1);
          end
`ifdef TILE_ARB_WATCHDOG_EN
          else if (rd_valid) begin
            wd_cnt <= '0;
          end else if (wd_cnt == 5'd15) begin
            // Sixteenth silent cycle: give up on the rest of the burst.
            err    <= 1'b1;
            state  <= IDLE;
            rr_ptr <= wrap_inc(owner, 1);
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 5'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_read_arbiter.sv
// Directed self-checking bench for tile_read_arbiter with a 2-cycle echoing buffer model.
module tb_tile_read_arbiter;

  localparam int DW = 8;
  localparam int TE = 32;
  localparam int NR = 2;
  localparam int CW = 10;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NR-1:0]                  req_valid;
  logic [NR-1:0][4:0]             req_buffer_id;
  logic [NR-1:0][CW-1:0]          req_num_tiles;
  logic [NR-1:0]                  req_ready;
  logic [NR-1:0]                  rsp_valid;
  logic signed [TE-1:0][DW-1:0]   rsp_tile;
  logic                           rsp_last;
  logic                           rd_enable;
  logic [4:0]                     rd_buffer_id;
  logic signed [TE-1:0][DW-1:0]   rd_tile;
  logic                           rd_valid;
  logic                           busy;
  logic                           err;

  // Buffer model: echoes rd_enable two cycles later, with per-cycle drop and stray controls.
  logic [1:0] pipe     = '0;
  logic [7:0] tile_seq = '0;
  logic       echo_on;
  logic       stray;

  int n_checks = 0;
  int n_fail   = 0;

  tile_read_arbiter #(
    .DATA_WIDTH(DW), .TILE_ELEMS(TE), .NUM_REQ(NR), .CNT_W(CW), .READ_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_buffer_id(req_buffer_id), .req_num_tiles(req_num_tiles),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_tile(rsp_tile), .rsp_last(rsp_last),
    .rd_enable(rd_enable), .rd_buffer_id(rd_buffer_id), .rd_tile(rd_tile), .rd_valid(rd_valid),
    .busy(busy), .err(err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    pipe     <= {pipe[0], rd_enable};
    tile_seq <= tile_seq + 8'd1;
  end

  assign rd_valid = (pipe[1] & echo_on) | stray;
  assign rd_tile  = {TE{tile_seq}};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    next_cycle;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_buffer_id = '0;
    req_num_tiles = '0;
    echo_on = 1'b1;
    stray = 1'b0;
    next_cycle;
    next_cycle;
    rst = 1'b0;

    // Reset state
    settle;
    check("reset_ready", req_ready, 0);
    check("reset_rd_enable", rd_enable, 0);
    check("reset_rd_id", rd_buffer_id, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_last", rsp_last, 0);

    // Single burst: req0 id=3 N=4, granted at T
    next_cycle;
    req_valid = 2'b01;
    req_buffer_id[0] = 5'd3;
    req_num_tiles[0] = 10'd4;
    settle;
    check("single_ready_T", req_ready, 2'b01);
    check("single_en_T", rd_enable, 0);
    for (int k = 1; k <= 7; k++) begin
      next_cycle;
      if (k == 1) req_valid = '0;
      settle;
      check("single_en", rd_enable, (k >= 1 && k <= 4) ? 1 : 0);
      if (k <= 4) check("single_id", rd_buffer_id, 3);
      check("single_rsp_valid", rsp_valid, (k >= 3 && k <= 6) ? 2'b01 : 2'b00);
      check("single_rsp_last", rsp_last, (k == 6) ? 1 : 0);
      check("single_busy", busy, (k <= 6) ? 1 : 0);
      check("single_ready", req_ready, 0);
      if (k >= 3 && k <= 6) check("single_tile", rsp_tile == rd_tile, 1);
    end
    check("single_err", err, 0);

    // Contention from reset, repeated twice to show round-robin alternation
    do_reset;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k <= 10; k++) begin
        if (k > 0 || rep > 0) next_cycle;
        if (k == 0) begin
          req_valid = 2'b11;
          req_buffer_id[0] = 5'd1; req_num_tiles[0] = 10'd2;
          req_buffer_id[1] = 5'd2; req_num_tiles[1] = 10'd3;
        end
        if (k == 1) req_valid[0] = 1'b0;
        if (k == 6) req_valid[1] = 1'b0;
        settle;
        check("cont_ready", req_ready, (k == 0) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00);
        check("cont_en", rd_enable, ((k >= 1 && k <= 2) || (k >= 6 && k <= 8)) ? 1 : 0);
        if (k >= 1) check("cont_id", rd_buffer_id, (k <= 5) ? 1 : 2);
        check("cont_rsp_valid", rsp_valid,
              (k >= 3 && k <= 4) ? 2'b01 : (k >= 8 && k <= 10) ? 2'b10 : 2'b00);
        check("cont_rsp_last", rsp_last, (k == 4 || k == 10) ? 1 : 0);
        check("cont_busy", busy, ((k >= 1 && k <= 4) || (k >= 6 && k <= 10)) ? 1 : 0);
      end
    end
    check("cont_err", err, 0);

    // Zero-length requests: accepted in one cycle, no reads, pointer advances
    next_cycle;
    req_valid = 2'b10;
    req_num_tiles = '0;
    settle;
    check("zero_ready_r1", req_ready, 2'b10);
    next_cycle;
    req_valid = 2'b01;
    settle;
    check("zero_ready_r0", req_ready, 2'b01);
    check("zero_en", rd_enable, 0);
    check("zero_busy", busy, 0);
    next_cycle;
    req_valid = 2'b11;
    settle;
    check("zero_rr_after_r0", req_ready, 2'b10);
    next_cycle;
    settle;
    check("zero_rr_after_r1", req_ready, 2'b01);
    next_cycle;
    req_valid = '0;
    settle;
    check("zero_en_after", rd_enable, 0);
    check("zero_busy_after", busy, 0);
    check("zero_rsp_valid", rsp_valid, 0);
    check("zero_err", err, 0);

    // Stray beat while idle
    next_cycle;
    stray = 1'b1;
    settle;
    check("stray_rsp_valid", rsp_valid, 0);
    check("stray_rsp_last", rsp_last, 0);
    check("stray_err_before", err, 0);
    next_cycle;
    stray = 1'b0;
    settle;
    check("stray_err_set", err, 1);
    next_cycle;
    next_cycle;
    next_cycle;
    settle;
    check("stray_err_sticky", err, 1);

    // Reset mid-burst, then a normal single-tile burst
    do_reset;
    settle;
    check("rst_clears_err", err, 0);
    next_cycle;
    next_cycle;
    req_valid = 2'b01;
    req_buffer_id[0] = 5'd5;
    req_num_tiles[0] = 10'd8;
    settle;
    check("mid_ready", req_ready, 2'b01);
    next_cycle;
    req_valid = '0;
    settle;
    check("mid_en1", rd_enable, 1);
    next_cycle;
    settle;
    check("mid_en2", rd_enable, 1);
    next_cycle;
    rst = 1'b1;
    settle;
    check("mid_en3", rd_enable, 1);
    next_cycle;
    rst = 1'b0;
    settle;
    check("mid_en_after_rst", rd_enable, 0);
    check("mid_busy_after_rst", busy, 0);
    check("mid_drop_rsp1", rsp_valid, 0);
    check("mid_err1", err, 0);
    next_cycle;
    settle;
    check("mid_drop_rsp2", rsp_valid, 0);
    check("mid_err2", err, 0);
    next_cycle;
    req_valid = 2'b01;
    req_buffer_id[0] = 5'd7;
    req_num_tiles[0] = 10'd1;
    settle;
    check("post_ready", req_ready, 2'b01);
    check("post_err", err, 0);
    next_cycle;
    req_valid = '0;
    settle;
    check("post_en", rd_enable, 1);
    check("post_id", rd_buffer_id, 7);
    next_cycle;
    settle;
    check("post_en_off", rd_enable, 0);
    check("post_busy_drain", busy, 1);
    check("post_rsp_early", rsp_valid, 0);
    next_cycle;
    settle;
    check("post_rsp_valid", rsp_valid, 2'b01);
    check("post_rsp_last", rsp_last, 1);
    next_cycle;
    settle;
    check("post_busy_done", busy, 0);
    check("post_err_done", err, 0);

    // Lost beat: N=2 with the second return suppressed
    next_cycle;
    req_valid = 2'b01;
    req_buffer_id[0] = 5'd9;
    req_num_tiles[0] = 10'd2;
    settle;
    check("lost_ready", req_ready, 2'b01);
    for (int k = 1; k <= 20; k++) begin
      next_cycle;
      if (k == 1) req_valid = '0;
      echo_on = (k != 4);
      settle;
      check("lost_rsp_valid", rsp_valid, (k == 3) ? 2'b01 : 2'b00);
      check("lost_rsp_last", rsp_last, 0);
`ifdef TILE_ARB_WATCHDOG_EN
      check("wd_err", err, (k == 20) ? 1 : 0);
      check("wd_busy", busy, (k <= 19) ? 1 : 0);
`else
      check("nowd_err", err, 0);
      check("nowd_busy", busy, 1);
`endif
    end
    echo_on = 1'b1;
    do_reset;
    settle;
    check("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_read_arbiter.md
Name: tile_read_arbiter

Overview:
- Shares the vector-buffer tile read port of the execution unit among NUM_REQ requesters, e.g. the matmul and activation sequencers.
- Each requester asks for a burst of N consecutive tiles from one buffer ID.
- The arbiter grants requesters round-robin and drives the read enable for exactly N cycles.
- It then waits for all N returned tiles and steers each one to the owning requester, tagging the final tile.

Parameters:
DATA_WIDTH, 8, bits per element
TILE_ELEMS, 32, elements per tile
NUM_REQ, 2, number of requesters (2..4)
CNT_W, 10, width of tile-count fields
READ_LATENCY, 2, cycles from rd_enable to rd_valid at the buffer port

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  [NUM_REQ]  burst request; held until req_ready
req_buffer_id  in  [NUM_REQ][5]  buffer ID per requester
req_num_tiles  in  [NUM_REQ][CNT_W]  tiles to read per requester
req_ready  out  [NUM_REQ]  one-cycle accept pulse
rsp_valid  out  [NUM_REQ]  returned tile valid, one-hot to owner
rsp_tile  out  [TILE_ELEMS][DATA_WIDTH] signed  returned tile (shared bus)
rsp_last  out  1  qualifies the final tile of a burst
rd_enable  out  1  read enable to buffer controller
rd_buffer_id  out  5  read buffer ID to buffer controller
rd_tile  in  [TILE_ELEMS][DATA_WIDTH] signed  tile data from buffer controller
rd_valid  in  1  read valid from buffer controller
busy  out  1  state != IDLE
err  out  1  sticky error flag

Behaviour:
- Reset: one clock, synchronous active-high reset (rst), sampled on posedge clk. All outputs are 0, state=IDLE, rr_ptr=0, counters=0. A reset mid-burst aborts the burst; rd_enable is 0 from the next edge, and the in-flight rd_valid beats that follow are dropped (not forwarded, no err).
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - When any req_valid is high, pick the first asserting index starting at rr_ptr, wrapping.
  - Pulse req_ready[g] for that cycle. Latch owner=g, id, and N=req_num_tiles[g].
  - If N==0: accept, issue no reads, no rsp, stay IDLE, rr_ptr=g+1 mod NUM_REQ.
  - Otherwise go to ISSUE.
- ISSUE:
  - rd_enable=1 and rd_buffer_id=id, registered, for exactly N consecutive cycles; the first cycle is the cycle after req_ready.
  - issue_cnt counts 0..N-1. After the Nth enable, go to DRAIN.
  - rd_buffer_id holds its last value when rd_enable=0.
- DRAIN: when rcv_cnt==N, go to IDLE and set rr_ptr=owner+1 mod NUM_REQ.
- Return path, valid in ISSUE and DRAIN:
  - Combinational pass-through with zero added latency: rsp_valid[owner]=rd_valid, rsp_tile=rd_tile.
  - Each rd_valid increments rcv_cnt. rsp_last=rd_valid && rcv_cnt==N-1.
  - rsp_tile is don't-care when no rsp_valid is high, but is driven to rd_tile.
- Unexpected rd_valid in IDLE, or once rcv_cnt==N: dropped, err<=1 (sticky until rst).
- Burst spacing: one IDLE cycle minimum between bursts. Back-to-back requests alternate between requesters under round-robin.
- Index reset: the downstream tile index resets when the buffer ID changes between bursts. Two consecutive bursts on the same ID continue the tile index; requesters rely on this.
- Simultaneous events: req_valid changes during ISSUE/DRAIN are ignored until IDLE. Arbitration is decided only in IDLE.
- Counters are CNT_W bits wide. N=2^CNT_W-1 is the maximum and must not wrap.

Optional Feature:
- Macro TILE_ARB_WATCHDOG_EN.
- Defined: a 5-bit watchdog counts DRAIN cycles with no rd_valid and clears on each rd_valid. When it reaches 16, set err<=1, drop the remainder of the burst (no rsp_last), and go to IDLE advancing rr_ptr. Any late rd_valid beats are then treated as unexpected.
- Undefined: DRAIN waits indefinitely; err is set only by unexpected beats.

Test Plan:
- Single burst: req0 valid, id=3, N=4, rd_valid echoed 2 cycles after rd_enable -> req_ready[0] pulses at T, rd_enable high T+1..T+4 with id 3, rsp_valid[0] at T+3..T+6, rsp_last at T+6, busy low at T+7.
- Contention: req0(id1,N=2) and req1(id2,N=3) asserted together from reset -> req0 granted first, then req1 after one IDLE cycle. A second simultaneous pair grants req1's successor by rr order (req0 then req1 alternating); rsp_valid is never routed to the wrong owner.
- Zero length: req1 N=0 -> req_ready[1] one cycle, rd_enable stays 0, no rsp_valid, rr_ptr advances to 0.
- Stray beat: rd_valid pulsed while IDLE -> no rsp_valid, err=1 and stays 1 until rst.
- Reset mid-burst: N=8, rst asserted at 3rd enable cycle -> rd_enable 0 next cycle, busy 0, err 0, and a subsequent req0 N=1 completes normally.
- Watchdog (TILE_ARB_WATCHDOG_EN): N=2, only one rd_valid returned -> err=1 exactly 16 DRAIN cycles later, state IDLE, no rsp_last.
